// File: rtl/wiscsc15_pkg.sv
// Package with the fixed encodings for the WISC-SC15 control unit: the
// opcodes, the ALU function codes, the datapath select values and the
// bundled control word passed from the decoder to the top level.
package wiscsc15_pkg;

  // Opcode map, taken from instruction bits [15:12]
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_NAND   = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_SLL    = 4'h5;
  localparam logic [3:0] OP_SRL    = 4'h6;
  localparam logic [3:0] OP_SRA    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_CALL   = 4'hD;
  localparam logic [3:0] OP_RET    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // ALU function codes; opcodes 0-7 map onto these directly
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_PADDSB = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_NAND   = 3'd3;
  localparam logic [2:0] ALU_XOR    = 3'd4;
  localparam logic [2:0] ALU_SLL    = 3'd5;
  localparam logic [2:0] ALU_SRL    = 3'd6;
  localparam logic [2:0] ALU_SRA    = 3'd7;

  // PC mux
  localparam logic PC_SRC_NOM = 1'b0;  // PC+2
  localparam logic PC_SRC_OFF = 1'b1;  // computed target

  // Register-file write address select
  localparam logic RF_WSRC_SP   = 1'b0;  // R15
  localparam logic RF_WSRC_INST = 1'b1;  // inst[11:8]

  // Register-file read port selects
  localparam logic [1:0] RSRC1_INST_7_4  = 2'd0;
  localparam logic [1:0] RSRC1_INST_11_8 = 2'd1;
  localparam logic [1:0] RSRC1_SP        = 2'd2;
  localparam logic [1:0] RSRC2_INST_3_0  = 2'd0;
  localparam logic [1:0] RSRC2_INST_11_8 = 2'd1;
  localparam logic [1:0] RSRC2_SP        = 2'd2;

  // ALU operand selects
  localparam logic       ALU_SRC1_RD1  = 1'b0;
  localparam logic       ALU_SRC1_PC   = 1'b1;
  localparam logic [1:0] ALU_SRC2_RD2  = 2'd0;
  localparam logic [1:0] ALU_SRC2_SIMM = 2'd1;
  localparam logic [1:0] ALU_SRC2_TWO  = 2'd2;
  localparam logic [1:0] ALU_SRC2_ZIMM = 2'd3;

  // Data memory selects
  localparam logic DM_IN_RD2    = 1'b0;
  localparam logic DM_IN_PC2    = 1'b1;
  localparam logic DM_ADDR_ALU  = 1'b0;
  localparam logic DM_ADDR_RD1  = 1'b1;

  // Write-back data select
  localparam logic [1:0] RF_DATA_ALU = 2'd0;
  localparam logic [1:0] RF_DATA_MEM = 2'd1;
  localparam logic [1:0] RF_DATA_LHB = 2'd2;
  localparam logic [1:0] RF_DATA_LLB = 2'd3;

  typedef struct packed {
    logic       pc_src;
    logic       rf_wsrc;
    logic [1:0] rf_rsrc1;
    logic [1:0] rf_rsrc2;
    logic       rf_w;
    logic       alu_src1;
    logic [1:0] alu_src2;
    logic       sel_call;
    logic       sel_branch;
    logic [2:0] aluop;
    logic       dm_in;
    logic       dm_addr;
    logic       dm_read;
    logic       dm_write;
    logic [1:0] rf_data;
  } ctrl_t;

  // Control word with every field at its idle value
  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c            = '0;
    c.pc_src     = PC_SRC_NOM;
    c.rf_wsrc    = RF_WSRC_INST;
    c.rf_rsrc1   = RSRC1_INST_7_4;
    c.rf_rsrc2   = RSRC2_INST_3_0;
    c.alu_src1   = ALU_SRC1_RD1;
    c.alu_src2   = ALU_SRC2_RD2;
    c.aluop      = ALU_ADD;
    c.dm_in      = DM_IN_RD2;
    c.dm_addr    = DM_ADDR_ALU;
    c.rf_data    = RF_DATA_ALU;
    return c;
  endfunction

endpackage

// File: rtl/wiscsc15_dec.sv
// Purely combinational opcode decoder for WISC-SC15.
// Ports:
//   opcode - instruction bits [15:12]
//   ctrl   - ungated control word (enables not yet masked by halt/reset)
module wiscsc15_dec
  import wiscsc15_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = ctrl_default();
    unique case (opcode)
      OP_ADD, OP_PADDSB, OP_SUB, OP_NAND, OP_XOR: begin
        ctrl.rf_w  = 1'b1;
        ctrl.aluop = opcode[2:0];
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        ctrl.rf_w     = 1'b1;
        ctrl.aluop    = opcode[2:0];
        ctrl.alu_src2 = ALU_SRC2_ZIMM;
      end
      OP_LW: begin
        ctrl.rf_w     = 1'b1;
        ctrl.alu_src2 = ALU_SRC2_SIMM;
        ctrl.aluop    = ALU_ADD;
        ctrl.dm_read  = 1'b1;
        ctrl.rf_data  = RF_DATA_MEM;
      end
      OP_SW: begin
        // Store data comes from the register named in inst[11:8]
        ctrl.rf_rsrc2 = RSRC2_INST_11_8;
        ctrl.alu_src2 = ALU_SRC2_SIMM;
        ctrl.aluop    = ALU_ADD;
        ctrl.dm_write = 1'b1;
        ctrl.dm_in    = DM_IN_RD2;
      end
      OP_LHB: begin
        // Old value of the destination is read back for the byte merge
        ctrl.rf_w     = 1'b1;
        ctrl.rf_rsrc1 = RSRC1_INST_11_8;
        ctrl.rf_data  = RF_DATA_LHB;
      end
      OP_LLB: begin
        ctrl.rf_w    = 1'b1;
        ctrl.rf_data = RF_DATA_LLB;
      end
      OP_B: begin
        ctrl.pc_src     = PC_SRC_OFF;
        ctrl.sel_branch = 1'b1;
      end
      OP_CALL: begin
        // SP <= SP-2 and mem[SP-2] <= PC+2 in one cycle
        ctrl.pc_src   = PC_SRC_OFF;
        ctrl.sel_call = 1'b1;
        ctrl.rf_rsrc1 = RSRC1_SP;
        ctrl.alu_src2 = ALU_SRC2_TWO;
        ctrl.aluop    = ALU_SUB;
        ctrl.rf_w     = 1'b1;
        ctrl.rf_wsrc  = RF_WSRC_SP;
        ctrl.dm_in    = DM_IN_PC2;
        ctrl.dm_write = 1'b1;
        ctrl.dm_addr  = DM_ADDR_ALU;
      end
      OP_RET: begin
        // Pop: read mem[SP] as the return target, SP <= SP+2
        ctrl.pc_src     = PC_SRC_OFF;
        ctrl.sel_call   = 1'b1;
        ctrl.sel_branch = 1'b1;
        ctrl.rf_rsrc1   = RSRC1_SP;
        ctrl.alu_src2   = ALU_SRC2_TWO;
        ctrl.aluop      = ALU_ADD;
        ctrl.rf_w       = 1'b1;
        ctrl.rf_wsrc    = RF_WSRC_SP;
        ctrl.dm_addr    = DM_ADDR_RD1;
        ctrl.dm_read    = 1'b1;
      end
      OP_HLT: begin
        ctrl = ctrl_default();
      end
      default: begin
        ctrl = ctrl_default();
      end
    endcase
  end

endmodule

// File: rtl/wiscsc15_ctrl_unit.sv
// WISC-SC15 decode-stage control unit. Decodes the opcode into datapath
// selects and enables, and holds the sticky halted flag.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   Opcode            - instruction bits [15:12]
//   pc_src .. rf_data - combinational control outputs
//   halt              - registered halted flag
//
// state      | meaning
// ST_RUN     | normal execution, enables follow the decode
// ST_HALTED  | HLT seen; all write/branch enables held at 0 until rst
module wiscsc15_ctrl_unit
  import wiscsc15_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Opcode,
  output logic       pc_src,
  output logic       rf_wsrc,
  output logic [1:0] rf_rsrc1,
  output logic [1:0] rf_rsrc2,
  output logic       rf_w,
  output logic       alu_src1,
  output logic [1:0] alu_src2,
  output logic       sel_call,
  output logic       sel_branch,
  output logic [2:0] aluop,
  output logic       dm_in,
  output logic       dm_addr,
  output logic       dm_read,
  output logic       dm_write,
  output logic [1:0] rf_data,
  output logic       halt
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} run_state_t;

  run_state_t state;
  ctrl_t      dec_ctrl;
  ctrl_t      out_ctrl;
  logic       block;

  wiscsc15_dec u_dec (
    .opcode (Opcode),
    .ctrl   (dec_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      halt  <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (Opcode == OP_HLT) begin
            state <= ST_HALTED;
            halt  <= 1'b1;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
          halt  <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
          halt  <= 1'b0;
        end
      endcase
    end
  end

  // HLT itself is masked combinationally so the halting instruction
  // cannot write even though the flag only rises at the next edge.
  assign block = halt | (Opcode == OP_HLT) | rst;

  always_comb begin
    out_ctrl = dec_ctrl;
    if (block) begin
      out_ctrl.rf_w       = 1'b0;
      out_ctrl.dm_read    = 1'b0;
      out_ctrl.dm_write   = 1'b0;
      out_ctrl.pc_src     = PC_SRC_NOM;
      out_ctrl.sel_call   = 1'b0;
      out_ctrl.sel_branch = 1'b0;
    end
  end

  assign pc_src     = out_ctrl.pc_src;
  assign rf_wsrc    = out_ctrl.rf_wsrc;
  assign rf_rsrc1   = out_ctrl.rf_rsrc1;
  assign rf_rsrc2   = out_ctrl.rf_rsrc2;
  assign rf_w       = out_ctrl.rf_w;
  assign alu_src1   = out_ctrl.alu_src1;
  assign alu_src2   = out_ctrl.alu_src2;
  assign sel_call   = out_ctrl.sel_call;
  assign sel_branch = out_ctrl.sel_branch;
  assign aluop      = out_ctrl.aluop;
  assign dm_in      = out_ctrl.dm_in;
  assign dm_addr    = out_ctrl.dm_addr;
  assign dm_read    = out_ctrl.dm_read;
  assign dm_write   = out_ctrl.dm_write;
  assign rf_data    = out_ctrl.rf_data;

endmodule

// File: tb/tb_wiscsc15_ctrl_unit.sv
// Scoreboard bench for wiscsc15_ctrl_unit: directed vectors push a
// hand-computed expected control word; a monitor pops and compares it on
// the falling edge of the cycle in which the vector is applied.
module tb_wiscsc15_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Opcode;
  logic       pc_src, rf_wsrc, rf_w, alu_src1, sel_call, sel_branch;
  logic       dm_in, dm_addr, dm_read, dm_write, halt;
  logic [1:0] rf_rsrc1, rf_rsrc2, alu_src2, rf_data;
  logic [2:0] aluop;

  int errors = 0;
  int checks = 0;

  logic [21:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  wiscsc15_ctrl_unit dut (
    .clk(clk), .rst(rst), .Opcode(Opcode),
    .pc_src(pc_src), .rf_wsrc(rf_wsrc), .rf_rsrc1(rf_rsrc1),
    .rf_rsrc2(rf_rsrc2), .rf_w(rf_w), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .sel_call(sel_call), .sel_branch(sel_branch),
    .aluop(aluop), .dm_in(dm_in), .dm_addr(dm_addr), .dm_read(dm_read),
    .dm_write(dm_write), .rf_data(rf_data), .halt(halt)
  );

  // Field order: pc wsrc r1 r2 w as1 as2 call br aop din dadr drd dwr rfd halt
  function automatic logic [21:0] ev(
    input logic pc, input logic ws, input logic [1:0] r1, input logic [1:0] r2,
    input logic w, input logic a1, input logic [1:0] a2, input logic sc,
    input logic sb, input logic [2:0] op, input logic di, input logic da,
    input logic rd, input logic wr, input logic [1:0] rfd, input logic h);
    return {pc, ws, r1, r2, w, a1, a2, sc, sb, op, di, da, rd, wr, rfd, h};
  endfunction

  task automatic apply(input logic r, input logic [3:0] op,
                       input logic [21:0] e, input string nm);
    @(posedge clk);
    #1;
    rst    = r;
    Opcode = op;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every falling edge with a pending expectation is a compare
  initial begin
    logic [21:0] act, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {pc_src, rf_wsrc, rf_rsrc1, rf_rsrc2, rf_w, alu_src1, alu_src2,
               sel_call, sel_branch, aluop, dm_in, dm_addr, dm_read, dm_write,
               rf_data, halt};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %06h expected %06h", nm, act, e);
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    Opcode = 4'h0;
    //           pc ws r1 r2 w a1 a2 sc sb aop din da rd wr rfd h
    apply(1, 4'h0, ev(0,1,0,0,0,0,0,0,0,3'd0,0,0,0,0,0,0), "reset_add");
    apply(0, 4'h0, ev(0,1,0,0,1,0,0,0,0,3'd0,0,0,0,0,0,0), "add");
    apply(0, 4'h1, ev(0,1,0,0,1,0,0,0,0,3'd1,0,0,0,0,0,0), "paddsb");
    apply(0, 4'h2, ev(0,1,0,0,1,0,0,0,0,3'd2,0,0,0,0,0,0), "sub");
    apply(0, 4'h3, ev(0,1,0,0,1,0,0,0,0,3'd3,0,0,0,0,0,0), "nand");
    apply(0, 4'h4, ev(0,1,0,0,1,0,0,0,0,3'd4,0,0,0,0,0,0), "xor");
    apply(0, 4'h5, ev(0,1,0,0,1,0,3,0,0,3'd5,0,0,0,0,0,0), "sll");
    apply(0, 4'h6, ev(0,1,0,0,1,0,3,0,0,3'd6,0,0,0,0,0,0), "srl");
    apply(0, 4'h7, ev(0,1,0,0,1,0,3,0,0,3'd7,0,0,0,0,0,0), "sra");
    apply(0, 4'h8, ev(0,1,0,0,1,0,1,0,0,3'd0,0,0,1,0,1,0), "lw");
    apply(0, 4'h9, ev(0,1,0,1,0,0,1,0,0,3'd0,0,0,0,1,0,0), "sw");
    apply(0, 4'hA, ev(0,1,1,0,1,0,0,0,0,3'd0,0,0,0,0,2,0), "lhb");
    apply(0, 4'hB, ev(0,1,0,0,1,0,0,0,0,3'd0,0,0,0,0,3,0), "llb");
    apply(0, 4'hC, ev(1,1,0,0,0,0,0,0,1,3'd0,0,0,0,0,0,0), "branch");
    apply(0, 4'hD, ev(1,0,2,0,1,0,2,1,0,3'd2,1,0,0,1,0,0), "call");
    apply(0, 4'hE, ev(1,0,2,0,1,0,2,1,1,3'd0,0,1,1,0,0,0), "ret");
    apply(0, 4'hF, ev(0,1,0,0,0,0,0,0,0,3'd0,0,0,0,0,0,0), "hlt");
    apply(0, 4'h0, ev(0,1,0,0,0,0,0,0,0,3'd0,0,0,0,0,0,1), "halted_add");
    apply(0, 4'h8, ev(0,1,0,0,0,0,1,0,0,3'd0,0,0,0,0,1,1), "halted_lw");
    apply(0, 4'hD, ev(0,0,2,0,0,0,2,0,0,3'd2,1,0,0,0,0,1), "halted_call");
    apply(1, 4'h0, ev(0,1,0,0,0,0,0,0,0,3'd0,0,0,0,0,0,1), "rst_while_halted");
    apply(0, 4'h0, ev(0,1,0,0,1,0,0,0,0,3'd0,0,0,0,0,0,0), "add_after_rst");
    apply(1, 4'hD, ev(0,0,2,0,0,0,2,0,0,3'd2,1,0,0,0,0,0), "call_in_rst");
    apply(1, 4'hF, ev(0,1,0,0,0,0,0,0,0,3'd0,0,0,0,0,0,0), "hlt_with_rst");
    apply(0, 4'h0, ev(0,1,0,0,1,0,0,0,0,3'd0,0,0,0,0,0,0), "rst_beats_hlt");
    apply(0, 4'h9, ev(0,1,0,1,0,0,1,0,0,3'd0,0,0,0,1,0,0), "sw_running");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
